// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the register file scoreboard.
// Configuration macro REGFILE_BYPASS_EN enables same-cycle write forwarding in the top.
package regfile_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read ports, writeback ports and load-scoreboard signals of the register file.
// master drives addresses/writes; slave returns read data, busy and stall.
interface regfile_scoreboard_if #(
    parameter int WIDTH = regfile_pkg::DEF_WIDTH,
    parameter int DEPTH = regfile_pkg::DEF_DEPTH
) ();
    import regfile_pkg::*;
    localparam int AW = addr_width(DEPTH);

    logic [AW-1:0]    ra_addr;
    logic [WIDTH-1:0] ra_data;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] rb_data;
    logic             alu_we;
    logic [AW-1:0]    alu_addr;
    logic [WIDTH-1:0] alu_data;
    logic             ld_issue;
    logic [AW-1:0]    ld_issue_addr;
    logic             ld_we;
    logic [AW-1:0]    ld_wb_addr;
    logic [WIDTH-1:0] ld_wb_data;
    logic [DEPTH-1:0] busy;
    logic             stall;

    modport master (
        output ra_addr, rb_addr, alu_we, alu_addr, alu_data,
               ld_issue, ld_issue_addr, ld_we, ld_wb_addr, ld_wb_data,
        input  ra_data, rb_data, busy, stall
    );

    modport slave (
        input  ra_addr, rb_addr, alu_we, alu_addr, alu_data,
               ld_issue, ld_issue_addr, ld_we, ld_wb_addr, ld_wb_data,
        output ra_data, rb_data, busy, stall
    );
endinterface

// File: rtl/regfile_word.sv
// One register word with write enable and synchronous active-high clear.
// Latency: written value visible one cycle after the enabling edge; no backpressure.
module regfile_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (reset) begin
            word_d = '0;
        end else if (en) begin
            word_d = d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign q = word_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read register file with ALU/load writeback and a per-register pending-load scoreboard.
// Reads and stall are combinational; writes/busy update next edge; REGFILE_BYPASS_EN forwards writes.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ZERO_R0 = 0
) (
    input logic            clk,
    input logic            reset,
    regfile_scoreboard_if.slave rf
);
    localparam int AW = addr_width(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] word_q;
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [WIDTH-1:0]            ra_dat, rb_dat;
    logic                        stall_a, stall_b;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic             alu_hit, ld_hit, wr_en;
        logic [WIDTH-1:0] wr_dat;

        assign alu_hit = rf.alu_we && (rf.alu_addr == AW'(gi));
        assign ld_hit  = rf.ld_we  && (rf.ld_wb_addr == AW'(gi));
        assign wr_en   = (alu_hit || ld_hit) && !((ZERO_R0 != 0) && (gi == 0));
        // ALU writeback wins a same-address collision with a load return
        assign wr_dat  = alu_hit ? rf.alu_data : rf.ld_wb_data;

        regfile_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en),
            .d     (wr_dat),
            .q     (word_q[gi])
        );
    end

    // A new issue to the register whose load is returning keeps it pending
    always_comb begin
        busy_d = busy_q;
        if (rf.ld_we)    busy_d[rf.ld_wb_addr]    = 1'b0;
        if (rf.ld_issue) busy_d[rf.ld_issue_addr] = 1'b1;
        if (ZERO_R0 != 0) busy_d[0] = 1'b0;
        if (reset)       busy_d = '0;
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    always_comb begin
        ra_dat  = word_q[rf.ra_addr];
        stall_a = busy_q[rf.ra_addr];
`ifdef REGFILE_BYPASS_EN
        if (rf.alu_we && (rf.alu_addr == rf.ra_addr)) ra_dat = rf.alu_data;
        else if (rf.ld_we && (rf.ld_wb_addr == rf.ra_addr)) ra_dat = rf.ld_wb_data;
        if (rf.ld_we && (rf.ld_wb_addr == rf.ra_addr)) stall_a = 1'b0;
`endif
        if ((ZERO_R0 != 0) && (rf.ra_addr == '0)) ra_dat = '0;
    end

    always_comb begin
        rb_dat  = word_q[rf.rb_addr];
        stall_b = busy_q[rf.rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (rf.alu_we && (rf.alu_addr == rf.rb_addr)) rb_dat = rf.alu_data;
        else if (rf.ld_we && (rf.ld_wb_addr == rf.rb_addr)) rb_dat = rf.ld_wb_data;
        if (rf.ld_we && (rf.ld_wb_addr == rf.rb_addr)) stall_b = 1'b0;
`endif
        if ((ZERO_R0 != 0) && (rf.rb_addr == '0)) rb_dat = '0;
    end

    assign rf.ra_data = ra_dat;
    assign rf.rb_data = rb_dat;
    assign rf.busy    = busy_q;
    assign rf.stall   = stall_a | stall_b;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a ZERO_R0=0 and a ZERO_R0=1 instance share one stimulus stream.
// Directed scenarios plus a randomized run against an array-based reference model.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  ra_addr = '0, rb_addr = '0, alu_addr = '0, ld_issue_addr = '0, ld_wb_addr = '0;
    logic        alu_we = 1'b0, ld_issue = 1'b0, ld_we = 1'b0;
    logic [15:0] alu_data = '0, ld_wb_data = '0;

    int tests = 0;
    int fails = 0;

    regfile_scoreboard_if #(.WIDTH(16), .DEPTH(16)) rf ();
    regfile_scoreboard_if #(.WIDTH(16), .DEPTH(16)) rfz ();

    assign rf.ra_addr = ra_addr;             assign rfz.ra_addr = ra_addr;
    assign rf.rb_addr = rb_addr;             assign rfz.rb_addr = rb_addr;
    assign rf.alu_we = alu_we;               assign rfz.alu_we = alu_we;
    assign rf.alu_addr = alu_addr;           assign rfz.alu_addr = alu_addr;
    assign rf.alu_data = alu_data;           assign rfz.alu_data = alu_data;
    assign rf.ld_issue = ld_issue;           assign rfz.ld_issue = ld_issue;
    assign rf.ld_issue_addr = ld_issue_addr; assign rfz.ld_issue_addr = ld_issue_addr;
    assign rf.ld_we = ld_we;                 assign rfz.ld_we = ld_we;
    assign rf.ld_wb_addr = ld_wb_addr;       assign rfz.ld_wb_addr = ld_wb_addr;
    assign rf.ld_wb_data = ld_wb_data;       assign rfz.ld_wb_data = ld_wb_data;

    regfile_scoreboard #(.WIDTH(16), .DEPTH(16), .ZERO_R0(0)) dut (
        .clk(clk), .reset(reset), .rf(rf));
    regfile_scoreboard #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1)) dutz (
        .clk(clk), .reset(reset), .rf(rfz));

    // Reference model: index 0 = plain instance, index 1 = ZERO_R0 instance
    logic [15:0] m_reg [2][16];
    logic [15:0] m_busy [2];

    function automatic logic [15:0] exp_rd(input int z, input logic [3:0] a);
        logic [15:0] v;
        v = m_reg[z][a];
`ifdef REGFILE_BYPASS_EN
        if (alu_we && alu_addr == a) v = alu_data;
        else if (ld_we && ld_wb_addr == a) v = ld_wb_data;
`endif
        if (z == 1 && a == 4'd0) v = 16'h0;
        return v;
    endfunction

    function automatic logic exp_pend(input int z, input logic [3:0] a);
        logic s;
        s = m_busy[z][a];
`ifdef REGFILE_BYPASS_EN
        if (ld_we && ld_wb_addr == a) s = 1'b0;
`endif
        return s;
    endfunction

    function automatic logic exp_stall(input int z);
        return exp_pend(z, ra_addr) | exp_pend(z, rb_addr);
    endfunction

    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) m_reg[z][i] = 16'h0;
                m_busy[z] = 16'h0;
            end else begin
                if (ld_we && !(z == 1 && ld_wb_addr == 4'd0)) m_reg[z][ld_wb_addr] = ld_wb_data;
                if (alu_we && !(z == 1 && alu_addr == 4'd0)) m_reg[z][alu_addr] = alu_data;
                if (ld_we) m_busy[z][ld_wb_addr] = 1'b0;
                if (ld_issue) m_busy[z][ld_issue_addr] = 1'b1;
                if (z == 1) m_busy[z][0] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        alu_we = 1'b0; ld_issue = 1'b0; ld_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step(); step();
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ra_addr = 4'(a); rb_addr = 4'(15 - a);
            #1;
            tests++;
            if (rf.ra_data !== 16'h0 || rf.rb_data !== 16'h0 || rfz.ra_data !== 16'h0) begin
                fails++;
                $display("FAIL reset_read addr %0d: got a=%h b=%h z=%h required 0", a, rf.ra_data, rf.rb_data, rfz.ra_data);
            end
        end
        tests++;
        if (rf.busy !== 16'h0 || rf.stall !== 1'b0 || rfz.busy !== 16'h0 || rfz.stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got busy=%h stall=%b zbusy=%h zstall=%b required 0", rf.busy, rf.stall, rfz.busy, rfz.stall);
        end
    endtask

    task automatic test_alu_write();
        alu_we = 1'b1; alu_addr = 4'd3; alu_data = 16'hBEEF; ra_addr = 4'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        tests++;
        if (rf.ra_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL alu_bypass: got %h required beef", rf.ra_data);
        end
`endif
        step();
        idle_inputs();
        #1;
        tests++;
        if (rf.ra_data !== 16'hBEEF || rfz.ra_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL alu_write: got %h/%h required beef", rf.ra_data, rfz.ra_data);
        end
    endtask

    task automatic test_load();
        ld_issue = 1'b1; ld_issue_addr = 4'd5;
        step();
        idle_inputs();
        rb_addr = 4'd5; ra_addr = 4'd1;
        #1;
        tests++;
        if (rf.stall !== 1'b1 || rf.busy[5] !== 1'b1 || rf.busy !== 16'h0020) begin
            fails++;
            $display("FAIL load_pending: got stall=%b busy=%h required 1/0020", rf.stall, rf.busy);
        end
        ld_we = 1'b1; ld_wb_addr = 4'd5; ld_wb_data = 16'h1234;
        #1;
        tests++;
`ifdef REGFILE_BYPASS_EN
        if (rf.stall !== 1'b0 || rf.rb_data !== 16'h1234) begin
            fails++;
            $display("FAIL load_bypass: got stall=%b data=%h required 0/1234", rf.stall, rf.rb_data);
        end
`else
        if (rf.stall !== 1'b1) begin
            fails++;
            $display("FAIL load_return_stall: got %b required 1", rf.stall);
        end
`endif
        step();
        idle_inputs();
        #1;
        tests++;
        if (rf.stall !== 1'b0 || rf.rb_data !== 16'h1234 || rf.busy[5] !== 1'b0) begin
            fails++;
            $display("FAIL load_return: got stall=%b data=%h busy5=%b required 0/1234/0", rf.stall, rf.rb_data, rf.busy[5]);
        end
    endtask

    task automatic test_collision();
        ld_issue = 1'b1; ld_issue_addr = 4'd7;
        step();
        idle_inputs();
        alu_we = 1'b1; alu_addr = 4'd7; alu_data = 16'hAAAA;
        ld_we = 1'b1; ld_wb_addr = 4'd7; ld_wb_data = 16'h5555;
        step();
        idle_inputs();
        ra_addr = 4'd7; rb_addr = 4'd0;
        #1;
        tests++;
        if (rf.ra_data !== 16'hAAAA || rf.busy[7] !== 1'b0) begin
            fails++;
            $display("FAIL collision: got data=%h busy7=%b required aaaa/0", rf.ra_data, rf.busy[7]);
        end
        ld_issue = 1'b1; ld_issue_addr = 4'd8; ld_we = 1'b1; ld_wb_addr = 4'd8; ld_wb_data = 16'h0F0F;
        step();
        idle_inputs();
        #1;
        tests++;
        if (rf.busy[8] !== 1'b1) begin
            fails++;
            $display("FAIL issue_over_return: got busy8=%b required 1", rf.busy[8]);
        end
    endtask

    task automatic test_zero_r0();
        alu_we = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF;
        step();
        idle_inputs();
        ra_addr = 4'd0; rb_addr = 4'd1;
        #1;
        tests++;
        if (rfz.ra_data !== 16'h0 || rf.ra_data !== 16'hFFFF) begin
            fails++;
            $display("FAIL zero_r0_read: got z=%h plain=%h required 0000/ffff", rfz.ra_data, rf.ra_data);
        end
        ld_issue = 1'b1; ld_issue_addr = 4'd0;
        step();
        idle_inputs();
        #1;
        tests++;
        if (rfz.busy[0] !== 1'b0 || rfz.stall !== 1'b0 || rf.busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL zero_r0_busy: got zbusy0=%b zstall=%b busy0=%b required 0/0/1", rfz.busy[0], rfz.stall, rf.busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        ld_issue = 1'b1; ld_issue_addr = 4'd9;
        step();
        idle_inputs();
        reset = 1'b1; alu_we = 1'b1; alu_addr = 4'd9; alu_data = 16'h7777;
        step();
        reset = 1'b0;
        idle_inputs();
        ra_addr = 4'd9; rb_addr = 4'd3;
        #1;
        tests++;
        if (rf.busy !== 16'h0 || rf.stall !== 1'b0 || rf.ra_data !== 16'h0 || rf.rb_data !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%h stall=%b ra=%h rb=%h required 0", rf.busy, rf.stall, rf.ra_data, rf.rb_data);
        end
        ld_we = 1'b1; ld_wb_addr = 4'd9; ld_wb_data = 16'h4321;
        step();
        idle_inputs();
        #1;
        tests++;
        if (rf.ra_data !== 16'h4321 || rf.busy !== 16'h0) begin
            fails++;
            $display("FAIL late_return: got data=%h busy=%h required 4321/0000", rf.ra_data, rf.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prev;
        prev = 16'h0;
        ra_addr = 4'd2;
        for (int i = 1; i <= 6; i++) begin
            alu_we = 1'b1; alu_addr = 4'd2; alu_data = 16'(i * 16'h1111);
            if (i > 1) begin
                #1;
                tests++;
                if (rf.ra_data !== exp_rd(0, 4'd2) || m_reg[0][2] !== prev) begin
                    fails++;
                    $display("FAIL back_to_back %0d: got %h required %h", i, rf.ra_data, exp_rd(0, 4'd2));
                end
            end
            prev = alu_data;
            step();
        end
        idle_inputs();
    endtask

    function automatic logic [3:0] rnd_addr();
        return ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            ra_addr = rnd_addr(); rb_addr = rnd_addr();
            alu_we = ($urandom_range(0, 2) == 0); alu_addr = rnd_addr(); alu_data = 16'($urandom);
            ld_issue = ($urandom_range(0, 2) == 0); ld_issue_addr = rnd_addr();
            ld_we = ($urandom_range(0, 2) == 0); ld_wb_addr = rnd_addr(); ld_wb_data = 16'($urandom);
            #1;
            tests++;
            if (rf.ra_data !== exp_rd(0, ra_addr) || rf.rb_data !== exp_rd(0, rb_addr) ||
                rf.stall !== exp_stall(0) || rf.busy !== m_busy[0] ||
                rfz.ra_data !== exp_rd(1, ra_addr) || rfz.rb_data !== exp_rd(1, rb_addr) ||
                rfz.stall !== exp_stall(1) || rfz.busy !== m_busy[1]) begin
                fails++;
                $display("FAIL random cycle %0d: got ra=%h rb=%h st=%b bz=%h | z ra=%h rb=%h st=%b bz=%h required ra=%h rb=%h st=%b bz=%h | z ra=%h rb=%h st=%b bz=%h",
                         n, rf.ra_data, rf.rb_data, rf.stall, rf.busy,
                         rfz.ra_data, rfz.rb_data, rfz.stall, rfz.busy,
                         exp_rd(0, ra_addr), exp_rd(0, rb_addr), exp_stall(0), m_busy[0],
                         exp_rd(1, ra_addr), exp_rd(1, rb_addr), exp_stall(1), m_busy[1]);
            end
            step();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 16; i++) m_reg[z][i] = 16'h0;
            m_busy[z] = 16'h0;
        end
        #1;
        test_reset();
        test_alu_write();
        test_load();
        test_collision();
        test_zero_r0();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of registers, a power of two, at least 2.
REQ-003 SHALL have parameter ZERO_R0, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL derive AW = log2(DEPTH) as the address width.
REQ-005 SHALL provide ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- ra_addr  in  AW  read port A address.
- ra_data  out  WIDTH  read port A data, combinational.
- rb_addr  in  AW  read port B address.
- rb_data  out  WIDTH  read port B data, combinational.
- alu_we  in  1  ALU writeback enable.
- alu_addr  in  AW  ALU writeback destination.
- alu_data  in  WIDTH  ALU writeback data.
- ld_issue  in  1  load issued; marks ld_issue_addr pending.
- ld_issue_addr  in  AW  load destination register.
- ld_we  in  1  load data return (writeback) enable.
- ld_wb_addr  in  AW  load writeback destination.
- ld_wb_data  in  WIDTH  load writeback data.
- busy  out  DEPTH  registered per-register pending-load bits.
- stall  out  1  combinational; high when either read address has a pending load.

Function
REQ-006 SHALL write alu_data to register alu_addr at the clock edge when alu_we=1.
REQ-007 SHALL write ld_wb_data to register ld_wb_addr at the clock edge when ld_we=1.
REQ-008 SHALL, when both writes target the same address in the same cycle, store alu_data (the ALU write wins) and clear that register's busy bit.
REQ-009 SHALL set busy[ld_issue_addr] at the clock edge when ld_issue=1.
REQ-010 SHALL clear busy[ld_wb_addr] at the clock edge when ld_we=1.
REQ-011 SHALL leave the busy bit set when ld_issue and ld_we target the same address in one cycle; the new issue wins.
REQ-012 SHALL leave other busy bits unchanged on any busy-bit update.
REQ-013 SHALL drive stall = busy[ra_addr] | busy[rb_addr], evaluated on the current busy bits.
REQ-014 SHALL, when ZERO_R0=1, return 0 on reads of address 0, never set busy[0], and drop writes to register 0.
REQ-015 SHALL hold every register with no write enabled in that cycle at its previous value.
REQ-016 SHALL NOT gate ld_issue with stall; preventing issue while stalled is the caller's responsibility.

Reset
REQ-017 SHALL, while reset=1 at a clock edge, clear all registers to 0 and all busy bits to 0; reset overrides all writes and issues in that cycle.
REQ-018 SHALL drive stall=0 and busy=0 in the cycle after reset, and read data 0 for every address.
REQ-019 SHALL discard pending loads when reset is asserted mid-operation; a later ld_we still writes its data normally.

Configuration
REQ-020 SHALL, with macro REGFILE_BYPASS_EN defined, forward a same-cycle write to a read port whose address matches; ALU data takes priority over load data.
REQ-021 SHALL, with REGFILE_BYPASS_EN defined, exclude from stall any address that ld_we is returning that cycle.
REQ-022 SHALL, without REGFILE_BYPASS_EN, return the pre-edge register value on reads and compute stall from busy bits only.

Structure
REQ-023 SHALL place the WIDTH and DEPTH defaults and the address-width function in the shared package regfile_pkg.
REQ-024 SHALL instantiate the sub-module regfile_word (WIDTH-bit register with enable and synchronous reset) DEPTH times in a generate loop.

Verification
REQ-025 SHALL cover: reset, then read all addresses -> all data 0, busy=0, stall=0.
REQ-026 SHALL cover: alu_we, addr 3, data 0xBEEF; next cycle ra_addr=3 -> ra_data=0xBEEF; with bypass, the same cycle -> 0xBEEF.
REQ-027 SHALL cover: ld_issue addr 5, then rb_addr=5 -> stall=1 and busy[5]=1; ld_we addr 5, data 0x1234 -> next cycle stall=0 and rb_data=0x1234.
REQ-028 SHALL cover: alu_we and ld_we to addr 7 (0xAAAA and 0x5555) in one cycle -> reg 7 = 0xAAAA, busy[7]=0.
REQ-029 SHALL cover: ZERO_R0=1, alu_we addr 0, data 0xFFFF -> ra_data for addr 0 = 0; ld_issue addr 0 -> busy[0]=0.
REQ-030 SHALL cover: ld_issue addr 9, reset for one cycle, then ra_addr=9 -> busy[9]=0, stall=0, ra_data=0.
